// File: rtl/bullet_sprite_painter.sv
// ============================================================================
// Module      : bullet_sprite_painter
// Description : Per-bullet repaint engine. On a frame tick it erases the box
//               drawn last time in the background colour, then draws the box
//               at the newly latched position. It emits one pixel per clock as
//               X/Y/colour/plot_enable for the object-to-paint selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_sprite_painter #(
    parameter int         W        = 4,
    parameter int         H        = 4,
    parameter int         X_MAX    = 319,
    parameter int         Y_MAX    = 239,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       active,
    input  logic [8:0] new_X,
    input  logic [7:0] new_Y,
    input  logic [2:0] bullet_color,
    output logic [8:0] VGA_X,
    output logic [7:0] VGA_Y,
    output logic [2:0] VGA_color,
    output logic       plot_enable,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_LAST = 4'(W - 1);
    localparam logic [3:0] ROW_LAST = 4'(H - 1);
    localparam logic [9:0] X_LIM    = 10'(X_MAX);
    localparam logic [8:0] Y_LIM    = 9'(Y_MAX);

    state_t     state, state_n;
    logic [3:0] col, col_n;
    logic [3:0] row, row_n;

    logic [8:0] pend_x;
    logic [7:0] pend_y;
    logic [2:0] pend_color;
    logic       pend_active;
    logic [8:0] old_x;
    logic [7:0] old_y;
    logic       has_drawn;

    logic       take_tick;
    logic       scan_last;
    logic       go_active;
    logic [8:0] draw_x;
    logic [7:0] draw_y;
    logic [2:0] draw_color;
    logic [8:0] base_x;
    logic [7:0] base_y;
    logic [2:0] color_n;
    logic [9:0] px;
    logic [8:0] py;
    logic       plot_n;

    // The state/counters describe the pixel currently on the outputs, so the
    // next-state logic also picks the pixel that becomes visible after the edge.
    always_comb begin
        state_n    = state;
        col_n      = col;
        row_n      = row;
        take_tick  = (state == S_IDLE) && frame_tick;
        scan_last  = (col == COL_LAST) && (row == ROW_LAST);
        // Active flag is taken straight from the input on the latching edge.
        go_active  = take_tick ? active : pend_active;
        draw_x     = take_tick ? new_X : pend_x;
        draw_y     = take_tick ? new_Y : pend_y;
        draw_color = take_tick ? bullet_color : pend_color;

        case (state)
            S_IDLE: begin
                col_n = 4'd0;
                row_n = 4'd0;
                if (frame_tick) begin
                    if (has_drawn)      state_n = S_ERASE;
                    else if (go_active) state_n = S_DRAW;
                    else                state_n = S_DONE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (scan_last) begin
                    col_n   = 4'd0;
                    row_n   = 4'd0;
                    state_n = (state == S_ERASE && go_active) ? S_DRAW : S_DONE;
                end else if (col == COL_LAST) begin
                    col_n = 4'd0;
                    row_n = row + 4'd1;
                end else begin
                    col_n = col + 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        base_x  = (state_n == S_ERASE) ? old_x    : draw_x;
        base_y  = (state_n == S_ERASE) ? old_y    : draw_y;
        color_n = (state_n == S_ERASE) ? BG_COLOR : draw_color;
        px      = {1'b0, base_x} + 10'(col_n);
        py      = {1'b0, base_y} + 9'(row_n);
        // Off-screen steps still take their cycle but never write.
        plot_n  = ((state_n == S_ERASE) || (state_n == S_DRAW)) &&
                  (px <= X_LIM) && (py <= Y_LIM);
    end

    // State, scan counters, latched request, drawn-box memory and registered pixel outputs.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            col         <= 4'd0;
            row         <= 4'd0;
            pend_x      <= 9'd0;
            pend_y      <= 8'd0;
            pend_color  <= 3'd0;
            pend_active <= 1'b0;
            old_x       <= 9'd0;
            old_y       <= 8'd0;
            has_drawn   <= 1'b0;
            VGA_X       <= 9'd0;
            VGA_Y       <= 8'd0;
            VGA_color   <= 3'd0;
            plot_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            if (take_tick) begin
                pend_x      <= new_X;
                pend_y      <= new_Y;
                pend_color  <= bullet_color;
                pend_active <= active;
            end
            if (state == S_DONE) begin
                if (pend_active) begin
                    old_x     <= pend_x;
                    old_y     <= pend_y;
                    has_drawn <= 1'b1;
                end else begin
                    has_drawn <= 1'b0;
                end
            end
            VGA_X       <= px[8:0];
            VGA_Y       <= py[7:0];
            VGA_color   <= color_n;
            plot_enable <= plot_n;
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bullet_sprite_painter.sv
// ============================================================================
// Module      : tb_bullet_sprite_painter
// Description : Scoreboard bench for bullet_sprite_painter. Each tick pushes
//               the expected per-cycle output sequence; a negedge monitor pops
//               and compares while the painter is busy and checks idleness
//               otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bullet_sprite_painter;

    localparam int         TW  = 4;
    localparam int         TH  = 4;
    localparam logic [2:0] BG  = 3'b000;

    logic       CLOCK_50;
    logic       rst;
    logic       frame_tick;
    logic       active;
    logic [8:0] new_X;
    logic [7:0] new_Y;
    logic [2:0] bullet_color;
    logic [8:0] VGA_X;
    logic [7:0] VGA_Y;
    logic [2:0] VGA_color;
    logic       plot_enable;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       p;
        logic       d;
        logic       chk_xy;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    logic       m_has = 1'b0;
    logic [8:0] m_ox  = 9'd0;
    logic [7:0] m_oy  = 8'd0;

    bullet_sprite_painter #(
        .W(TW), .H(TH), .X_MAX(319), .Y_MAX(239), .BG_COLOR(BG)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .active       (active),
        .new_X        (new_X),
        .new_Y        (new_Y),
        .bullet_color (bullet_color),
        .VGA_X        (VGA_X),
        .VGA_Y        (VGA_Y),
        .VGA_color    (VGA_color),
        .plot_enable  (plot_enable),
        .busy         (busy),
        .done         (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Monitor: busy cycles consume scoreboard entries, idle cycles must be quiet.
    always @(negedge CLOCK_50) begin
        if (!rst) begin
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (busy !== 1'b1 || plot_enable !== e.p || done !== e.d ||
                    (e.chk_xy && (VGA_X !== e.x || VGA_Y !== e.y)) ||
                    (e.p && VGA_color !== e.c)) begin
                    errors++;
                    $display("FAIL pixel t=%0t: got busy=%b plot=%b done=%b x=%0d y=%0d c=%b, want busy=1 plot=%b done=%b x=%0d y=%0d c=%b (xy checked=%b)",
                             $time, busy, plot_enable, done, VGA_X, VGA_Y, VGA_color,
                             e.p, e.d, e.x, e.y, e.c, e.chk_xy);
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || plot_enable !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle t=%0t: got busy=%b plot=%b done=%b, want 0 0 0",
                             $time, busy, plot_enable, done);
                end
            end
        end
    end

    task automatic push_box(input logic [8:0] bx, input logic [7:0] by, input logic [2:0] c);
        for (int r = 0; r < TH; r++) begin
            for (int k = 0; k < TW; k++) begin
                exp_t       e;
                logic [9:0] x10;
                logic [8:0] y9;
                x10      = {1'b0, bx} + 10'(k);
                y9       = {1'b0, by} + 9'(r);
                e.x      = x10[8:0];
                e.y      = y9[7:0];
                e.c      = c;
                e.p      = (x10 <= 10'd319) && (y9 <= 9'd239);
                e.d      = 1'b0;
                e.chk_xy = 1'b1;
                sbq.push_back(e);
            end
        end
    endtask

    // Pulses frame_tick for one edge and queues the expected repaint.
    task automatic do_tick(input logic a, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        exp_t e;
        @(posedge CLOCK_50); #1;
        frame_tick = 1'b1; active = a; new_X = x; new_Y = y; bullet_color = c;
        @(posedge CLOCK_50); #1;
        frame_tick   = 1'b0;
        active       = 1'($urandom);
        new_X        = 9'($urandom);
        new_Y        = 8'($urandom);
        bullet_color = 3'($urandom);
        if (m_has) push_box(m_ox, m_oy, BG);
        if (a) push_box(x, y, c);
        e = '0;
        e.d = 1'b1;
        sbq.push_back(e);
        if (a) begin
            m_ox  = x;
            m_oy  = y;
            m_has = 1'b1;
        end else begin
            m_has = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d expected cycles never seen, want 0", name, sbq.size());
            sbq.delete();
        end
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 1'b1; active = 1'b1;
        new_X = 9'd7; new_Y = 8'd9; bullet_color = 3'b111;
        #3;
        repeat (3) begin
            @(negedge CLOCK_50);
            checks++;
            if (VGA_X !== 9'd0 || VGA_Y !== 8'd0 || VGA_color !== 3'd0 ||
                plot_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b, want all 0",
                         VGA_X, VGA_Y, VGA_color, plot_enable, busy, done);
            end
        end
        frame_tick = 1'b0;
        @(posedge CLOCK_50); #1;
        rst = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_first_draw();
        do_tick(1'b1, 9'd50, 8'd60, 3'b100);
        wait_idle("first_draw");
    endtask

    task automatic test_move();
        do_tick(1'b1, 9'd54, 8'd60, 3'b100);
        wait_idle("move");
    endtask

    task automatic test_deactivate();
        do_tick(1'b0, 9'd0, 8'd0, 3'b000);
        wait_idle("deactivate_erase");
        do_tick(1'b0, 9'd1, 8'd1, 3'b011);
        wait_idle("no_op_repaint");
    endtask

    task automatic test_clipping();
        do_tick(1'b1, 9'd318, 8'd238, 3'b010);
        wait_idle("clip_corner");
        do_tick(1'b0, 9'd0, 8'd0, 3'b000);
        wait_idle("clip_erase");
    endtask

    task automatic test_tick_ignored_and_abort();
        do_tick(1'b1, 9'd100, 8'd100, 3'b111);
        for (int cyc = 2; cyc <= 8; cyc++) begin
            @(posedge CLOCK_50); #1;
            if (cyc == 5) begin
                frame_tick = 1'b1; active = 1'b1; new_X = 9'd200; new_Y = 8'd10; bullet_color = 3'b001;
            end
            if (cyc == 6) frame_tick = 1'b0;
            if (cyc == 8) begin
                rst = 1'b1;
                #1;
                checks++;
                if (VGA_X !== 9'd0 || VGA_Y !== 8'd0 || VGA_color !== 3'd0 ||
                    plot_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL async_abort: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b, want all 0",
                             VGA_X, VGA_Y, VGA_color, plot_enable, busy, done);
                end
                sbq.delete();
                m_has = 1'b0;
            end
        end
        @(posedge CLOCK_50); #1;
        rst = 1'b0;
        @(posedge CLOCK_50); #1;
        do_tick(1'b1, 9'd10, 8'd20, 3'b001);
        wait_idle("after_abort_draw");
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; active = 1'b0;
        new_X = 9'd0; new_Y = 8'd0; bullet_color = 3'd0;
        test_reset();
        test_first_draw();
        test_move();
        test_deactivate();
        test_clipping();
        test_tick_ignored_and_abort();
        repeat (2) @(posedge CLOCK_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
